// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the MEM stage.
// Hits are served combinationally; misses stall the pipeline while the line is
// written back (if dirty) and refilled from the line-wide memory.
module dcache_ctrl #(
    parameter int unsigned LINES = 32,
    parameter int unsigned WORDS = 8,
    parameter int unsigned TAG_W = 22
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic [31:0]           Address_i,
    input  logic [31:0]           Write_data_i,
    output logic [31:0]           Read_data_o,
    output logic                  stall_o,
    output logic                  mem_enable_o,
    output logic                  mem_write_o,
    output logic [31:0]           mem_addr_o,
    output logic [WORDS*32-1:0]   mem_data_o,
    input  logic [WORDS*32-1:0]   mem_data_i,
    input  logic                  mem_ack_i
);

    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned OFF_W  = $clog2(WORDS);
    localparam int unsigned BLK_W  = OFF_W + 2;
    localparam int unsigned LINE_W = WORDS * 32;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [LINES-1:0]  r_valid;
    logic [LINES-1:0]  r_dirty;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [LINE_W-1:0] r_data [LINES];

    logic [OFF_W-1:0]   w_off;
    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [OFF_W+4:0]   w_bit;
    logic [LINE_W-1:0]  w_line;
    logic [TAG_W-1:0]   w_vtag;
    logic [31:0]        w_word;
    logic               w_req;
    logic               w_hit;
    logic               w_wr_hit;
    logic               w_fill;
    logic               w_unused;

    // Address decode and lookup of the indexed line
    assign w_off    = Address_i[BLK_W-1:2];
    assign w_idx    = Address_i[BLK_W+IDX_W-1:BLK_W];
    assign w_tag    = Address_i[31:BLK_W+IDX_W];
    assign w_bit    = {w_off, 5'b0};
    assign w_line   = r_data[w_idx];
    assign w_vtag   = r_tag[w_idx];
    assign w_word   = w_line[w_bit +: 32];
    assign w_req    = MemRead_i | MemWrite_i;
    assign w_hit    = w_req & r_valid[w_idx] & (w_vtag == w_tag);
    assign w_unused = ^Address_i[1:0];

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, memory interface and pipeline-facing outputs
    always_comb begin
        w_state_next = r_state;
        stall_o      = 1'b0;
        Read_data_o  = 32'h0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = 32'h0;
        mem_data_o   = LINE_W'(0);
        w_wr_hit     = 1'b0;
        w_fill       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_hit) begin
                        // a simultaneous read+write is treated as a write
                        if (MemWrite_i) begin
                            w_wr_hit = 1'b1;
                        end else begin
                            Read_data_o = w_word;
                        end
                    end else begin
                        stall_o      = 1'b1;
                        w_state_next = (r_valid[w_idx] & r_dirty[w_idx]) ? S_WRITEBACK
                                                                         : S_ALLOCATE;
                    end
                end
            end
            S_WRITEBACK: begin
                stall_o      = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {w_vtag, w_idx, BLK_W'(0)};
                mem_data_o   = w_line;
                if (mem_ack_i) begin
                    w_state_next = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                stall_o      = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {w_tag, w_idx, BLK_W'(0)};
                if (mem_ack_i) begin
                    w_fill       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Valid/dirty bookkeeping; cleared by reset so pending requests miss again
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (w_fill) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
        end else if (w_wr_hit) begin
            r_dirty[w_idx] <= 1'b1;
        end
    end

    // Tag and data arrays: refill whole line or update one word on a write hit
    always_ff @(posedge clk_i) begin
        if (w_fill) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= mem_data_i;
        end else if (w_wr_hit) begin
            r_data[w_idx][w_bit +: 32] <= Write_data_i;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed vector table, reset-mid-refill
// sequence and randomized accesses against a transparent-memory reference.
module tb_dcache_ctrl;

    logic         clk;
    logic         rst_i;
    logic         MemRead_i;
    logic         MemWrite_i;
    logic [31:0]  Address_i;
    logic [31:0]  Write_data_i;
    logic [31:0]  Read_data_o;
    logic         stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    dcache_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .MemRead_i    (MemRead_i),
        .MemWrite_i   (MemWrite_i),
        .Address_i    (Address_i),
        .Write_data_i (Write_data_i),
        .Read_data_o  (Read_data_o),
        .stall_o      (stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Backing memory (128 lines = addresses below 0x1000) and the word view
    // the processor must observe regardless of what the cache holds.
    logic [255:0] bmem [128];
    logic [31:0]  gmem [1024];
    // Reference cache directory: which line each index holds
    bit           mv [32];
    bit           md [32];
    int           mt [32];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat_wb;
        int          lat_al;
        int          exp_stall;
        logic        exp_wb;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [9];

    function automatic logic [31:0] pat(int l, int w);
        return 32'hA500_0000 | 32'(l << 8) | 32'(w);
    endfunction

    function automatic logic [255:0] gline(int l);
        logic [255:0] v;
        for (int w = 0; w < 8; w++) v[w*32 +: 32] = gmem[l*8 + w];
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reset forgets everything the cache held; un-written-back stores are lost
    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mv[i] = 0;
            md[i] = 0;
            mt[i] = 0;
        end
        for (int l = 0; l < 128; l++)
            for (int w = 0; w < 8; w++) gmem[l*8 + w] = bmem[l][w*32 +: 32];
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        mem_ack_i  = 1'b0;
        #1;
        chk("idle_stall", stall_o, 0);
        chk("idle_rdata", Read_data_o, 0);
        chk("idle_mem_en", mem_enable_o, 0);
        @(posedge clk);
    endtask

    // One pipeline access, acting as the memory (ack in the lat-th request cycle)
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int lat_wb, input int lat_al,
                             output int st, output logic wb, output logic [31:0] rdat);
        int   idx   = int'(addr[9:5]);
        int   tg    = int'(addr[11:10]);
        int   line  = int'(addr[11:5]);
        int   wi    = int'(addr[11:2]);
        bit   m_hit = mv[idx] && (mt[idx] == tg);
        bit   e_wb  = !m_hit && mv[idx] && md[idx];
        int   e_st  = m_hit ? 0 : 1 + (e_wb ? lat_wb : 0) + lat_al;
        int   vline = mt[idx] * 32 + idx;
        int   en_cnt = 0;
        bit   done = 0;
        bit   wr_txn = 0;
        st   = 0;
        wb   = 1'b0;
        rdat = 32'h0;
        @(negedge clk);
        MemRead_i    = rd;
        MemWrite_i   = wr;
        Address_i    = addr;
        Write_data_i = wdata;
        mem_ack_i    = 1'b0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                mem_ack_i = 1'b0;
            end
            #1;
            if (!stall_o) begin
                rdat = Read_data_o;
                done = 1;
                chk("served_mem_en", mem_enable_o, 0);
            end else begin
                st++;
                if (mem_enable_o) begin
                    if (en_cnt == 0) begin
                        wr_txn = mem_write_o;
                        if (mem_write_o) begin
                            chk("wb_allowed", 1'b1, e_wb && !wb);
                            chk("wb_addr", mem_addr_o, 32'(vline * 32));
                        end else begin
                            chk("fetch_addr", mem_addr_o, {addr[31:5], 5'b0});
                        end
                    end
                    en_cnt++;
                    if (en_cnt == (wr_txn ? lat_wb : lat_al)) begin
                        mem_ack_i = 1'b1;
                        en_cnt    = 0;
                        if (wr_txn) begin
                            wb = 1'b1;
                            chk("wb_data", mem_data_o, gline(vline));
                            bmem[vline] = mem_data_o;
                        end else begin
                            mem_data_i = bmem[line];
                        end
                    end
                end
            end
            @(posedge clk);
        end
        if (!done) begin
            n_vec++;
            n_miss++;
            $display("FAIL timeout: access to %0h still stalled after 100 cycles", addr);
        end
        chk("stall_cycles", st, e_st);
        chk("wb_done", wb, e_wb);
        if (rd && !wr) chk("rdata", rdat, gmem[wi]);
        mv[idx] = 1;
        mt[idx] = tg;
        if (!m_hit) md[idx] = 0;
        if (wr) begin
            md[idx]  = 1;
            gmem[wi] = wdata;
        end
    endtask

    int          st;
    logic        wbd;
    logic [31:0] rdat;

    initial begin
        rst_i        = 1'b0;
        MemRead_i    = 1'b0;
        MemWrite_i   = 1'b0;
        Address_i    = 32'h0;
        Write_data_i = 32'h0;
        mem_data_i   = 256'h0;
        mem_ack_i    = 1'b0;

        for (int l = 0; l < 128; l++)
            for (int w = 0; w < 8; w++) bmem[l][w*32 +: 32] = pat(l, w);
        bmem[2][63:32] = 32'hDEAD_BEEF;
        model_reset();

        //         rd    wr    addr          wdata         wb al stall wb  chk  rdata
        tbl[0] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,        0, 10, 11, 1'b0, 1'b1, 32'hDEAD_BEEF};
        tbl[1] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,        0, 1,  0,  1'b0, 1'b1, 32'hDEAD_BEEF};
        tbl[2] = '{1'b0, 1'b1, 32'h0000_0044, 32'h1234_5678, 0, 1,  0,  1'b0, 1'b0, 32'h0};
        tbl[3] = '{1'b1, 1'b0, 32'h0000_0444, 32'h0,        3, 4,  8,  1'b1, 1'b1, pat(34, 1)};
        tbl[4] = '{1'b1, 1'b0, 32'h0000_0844, 32'h0,        1, 2,  3,  1'b0, 1'b1, pat(66, 1)};
        tbl[5] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,        1, 5,  6,  1'b0, 1'b1, 32'h1234_5678};
        tbl[6] = '{1'b1, 1'b1, 32'h0000_0048, 32'hCAFE_F00D, 1, 1,  0,  1'b0, 1'b0, 32'h0};
        tbl[7] = '{1'b1, 1'b0, 32'h0000_0048, 32'h0,        1, 1,  0,  1'b0, 1'b1, 32'hCAFE_F00D};
        tbl[8] = '{1'b1, 1'b0, 32'h0000_0848, 32'h0,        2, 1,  4,  1'b1, 1'b1, pat(66, 2)};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_stall", stall_o, 0);
        chk("rst_mem_en", mem_enable_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_rdata", Read_data_o, 0);
        rst_i = 1'b1;
        idle_cycle();

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            do_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                      tbl[i].lat_wb, tbl[i].lat_al, st, wbd, rdat);
            chk($sformatf("tbl%0d_stall", i), st, tbl[i].exp_stall);
            chk($sformatf("tbl%0d_wb", i), wbd, tbl[i].exp_wb);
            if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), rdat, tbl[i].exp_rd);
        end
        idle_cycle();

        // Reset while a refill is outstanding, then a stray ack
        @(negedge clk);
        MemRead_i = 1'b1;
        Address_i = 32'h0000_0100;
        #1;
        chk("rr_miss_stall", stall_o, 1);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rr_alloc_en", mem_enable_o, 1);
            chk("rr_alloc_wr", mem_write_o, 0);
            chk("rr_alloc_addr", mem_addr_o, 32'h100);
            @(posedge clk);
        end
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        chk("rr_in_rst_stall", stall_o, 1);
        chk("rr_in_rst_en", mem_enable_o, 0);
        chk("rr_in_rst_wr", mem_write_o, 0);
        chk("rr_in_rst_addr", mem_addr_o, 0);
        chk("rr_in_rst_data", mem_data_o, 0);
        @(posedge clk);
        @(negedge clk);
        rst_i      = 1'b1;
        MemRead_i  = 1'b0;
        mem_ack_i  = 1'b1;
        mem_data_i = {8{32'hBADB_AD00}};
        #1;
        chk("rr_stray_stall", stall_o, 0);
        chk("rr_stray_en", mem_enable_o, 0);
        @(posedge clk);
        model_reset();
        do_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1, 3, st, wbd, rdat);
        chk("rr_refetch_stall", st, 4);
        chk("rr_refetch_rdata", rdat, pat(8, 0));
        do_access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 1, 2, st, wbd, rdat);
        chk("rr_lost_line_stall", st, 3);

        // Randomized traffic over a few conflicting indices
        for (int i = 0; i < 200; i++) begin
            int          k;
            logic [31:0] a;
            k = int'($urandom_range(0, 9));
            if (k == 0) begin
                idle_cycle();
            end else begin
                a = 32'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 5) |
                        ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
                k = int'($urandom_range(0, 2));
                do_access(k != 1, k != 0, a, $urandom, int'($urandom_range(1, 4)),
                          int'($urandom_range(1, 4)), st, wbd, rdat);
            end
        end
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Data-cache controller for the MEM stage of the 5-stage pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes its MemRead, MemWrite, Address and Write_data outputs. It is a direct-mapped, write-back, write-allocate cache in front of a slow line-wide data memory. On a miss it raises stall_o, which the top level inverts into pcEnable to freeze PC, IF/ID, ID/EX and EX/MEM.

Parameters:
LINES, 32, number of cache lines (power of two; index width IDX_W = log2(LINES))
WORDS, 8, 32-bit words per line (line = 256 bits; offset field = address bits [4:2])
TAG_W, 22, tag width = 32 - 5 - IDX_W

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-low reset
MemRead_i  input  1  load request from EX/MEM
MemWrite_i  input  1  store request from EX/MEM
Address_i  input  32  byte address; bits [1:0] ignored
Write_data_i  input  32  store data
Read_data_o  output  32  load data to MEM/WB
stall_o  output  1  1 = pipeline must hold (pcEnable = ~stall_o)
mem_enable_o  output  1  memory request valid
mem_write_o  output  1  1 = line write-back, 0 = line fetch
mem_addr_o  output  32  line-aligned address ({tag,index,5'b0})
mem_data_o  output  256  line being written back
mem_data_i  input  256  fetched line
mem_ack_i  input  1  one-cycle completion pulse from memory

Behaviour:
- Address split: offset = [4:2], index = [IDX_W+4:5], tag = [31:IDX_W+5].
- Storage: per line valid, dirty, tag, 256-bit data. Only valid and dirty are reset; tag and data arrays are not reset.
- req = MemRead_i | MemWrite_i. If both are set, the access is a write and the read data is don't-care.
- hit = req & valid[index] & (tag[index] == tag).
- States: IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - Read hit: Read_data_o = addressed word, combinational in the same cycle; stall_o = 0.
  - Write hit: addressed word updated and dirty set at the clock edge; stall_o = 0.
  - Miss (req & ~hit): stall_o = 1 combinationally in the same cycle. Next state is WRITEBACK if the victim is valid & dirty, else ALLOCATE.
  - No req: stall_o = 0, Read_data_o = 0, memory outputs idle.
- WRITEBACK:
  - mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_data_o = victim line.
  - Held until mem_ack_i, then go to ALLOCATE.
- ALLOCATE:
  - mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {req tag, index, 5'b0}.
  - On mem_ack_i: line ← mem_data_i, tag written, valid = 1, dirty = 0; go to IDLE.
- stall_o = 1 throughout WRITEBACK and ALLOCATE.
- After a refill, the next cycle is IDLE and the held request now hits. That cycle serves the read or applies the write and sets dirty, and stall_o drops.
- Miss penalty: clean miss = (ack latency + 1) cycles of stall; dirty miss adds the write-back ack latency.
- The pipeline freeze keeps Address_i, Write_data_i and the request lines stable while stall_o = 1. The controller latches nothing from them.
- mem_ack_i outside WRITEBACK/ALLOCATE is ignored.
- All outputs are driven from state plus the current inputs. mem_enable_o is 0 in IDLE.
- Reset (async, any state including mid-refill):
  - FSM → IDLE; all valid and dirty bits cleared.
  - stall_o follows req (a pending request misses again).
  - mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0.
  - A late mem_ack_i after reset is ignored.

Test Plan:
- Cold read miss: reset, MemRead_i=1, Address_i=0x0000_0044, memory acks after 10 cycles with word1 = 0xDEADBEEF → stall_o high 11 cycles, one fetch with mem_addr_o=0x40 and mem_write_o=0, then Read_data_o=0xDEADBEEF with stall_o=0.
- Read hit: repeat the same read immediately → stall_o=0 in the request cycle, no mem_enable_o pulse.
- Write hit then conflict miss: write 0x12345678 to 0x44 (hit), then read 0x0000_0444 (same index, different tag) → WRITEBACK to 0x40 with mem_data_o word1 = 0x12345678, then ALLOCATE of 0x440, then data returned.
- Clean conflict miss: read 0x844 after the line was refilled clean → no write-back, ALLOCATE only.
- Reset mid-ALLOCATE: assert rst_i=0 during the wait, deassert, then deliver a stray mem_ack_i → ignored; the held request misses again and refetches.
- Both MemRead_i and MemWrite_i set on a hit → treated as a write, dirty set, stall_o=0.
